intersection_sequencer: RTL

//  Two-road (NS/EW) intersection scheduler with its own loadable countdown timer.

---
 rtl/traffic_pkg.sv | 40 ++++
 rtl/phase_timer.sv | 35 +++
 rtl/intersection_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_pkg: phase codes, lamp encodings and lamp decode helper      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_NS_G  = 3'd0,
        PH_NS_Y  = 3'd1,
        PH_AR_A  = 3'd2,
        PH_EW_G  = 3'd3,
        PH_EW_Y  = 3'd4,
        PH_AR_B  = 3'd5,
        PH_WALK  = 3'd6,
        PH_FLASH = 3'd7
    } phase_e;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_G   = 3'b010;
    localparam logic [2:0] LAMP_Y   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Returns {ns, ew}; any phase without a road green/yellow shows all-red.
    function automatic logic [5:0] lamp_decode(input phase_e ph, input logic flash);
        logic [5:0] lamps;
        lamps = {LAMP_R, LAMP_R};
        case (ph)
            PH_NS_G:  lamps = {LAMP_G, LAMP_R};
            PH_NS_Y:  lamps = {LAMP_Y, LAMP_R};
            PH_EW_G:  lamps = {LAMP_R, LAMP_G};
            PH_EW_Y:  lamps = {LAMP_R, LAMP_Y};
            PH_FLASH: lamps = flash ? {LAMP_Y, LAMP_Y} : {LAMP_OFF, LAMP_OFF};
            default:  lamps = {LAMP_R, LAMP_R};
        endcase
        return lamps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | phase_timer: 8-bit loadable down-counter, stops at 1, expires on tick|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module phase_timer #(
    parameter logic [7:0] RST_VAL = 8'd2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick,
    input  logic       ld,
    input  logic [7:0] ld_val,
    output logic [7:0] count,
    output logic       expire
);

    logic [7:0] r_count;

    // Load has priority; a zero count (flash) never decrements or expires.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= RST_VAL;
        end else if (ld) begin
            r_count <= ld_val;
        end else if (tick && (r_count > 8'd1)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign count  = r_count;
    assign expire = tick & (r_count == 8'd1);

endmodule
`default_nettype wire

// File: rtl/intersection_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | intersection_sequencer: NS/EW/pedestrian scheduler with night flash  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module intersection_sequencer
    import traffic_pkg::*;
#(
    parameter logic [7:0] T_GREEN  = 8'd30,
    parameter logic [7:0] T_YELLOW = 8'd5,
    parameter logic [7:0] T_ALLRED = 8'd2,
    parameter logic [7:0] T_WALK   = 8'd10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic [7:0] count,
    output logic       load,
    output logic       ped_walk,
    output logic [2:0] phase
);

    phase_e     r_phase;
    phase_e     w_nxt_phase;
    logic       r_flash;
    logic       w_nxt_flash;
    logic       r_ped_pending;
    logic       r_load;
    logic [2:0] r_light_ns;
    logic [2:0] r_light_ew;
    logic       w_ld;
    logic [7:0] w_ld_val;
    logic       w_expire;
    logic [7:0] w_count;
    logic       w_enter_walk;
    logic [5:0] w_lamps;

    function automatic logic [7:0] phase_duration(input phase_e ph);
        logic [7:0] dur;
        dur = T_ALLRED;
        case (ph)
            PH_NS_G, PH_EW_G: dur = T_GREEN;
            PH_NS_Y, PH_EW_Y: dur = T_YELLOW;
            PH_WALK:          dur = T_WALK;
            PH_FLASH:         dur = 8'd0;
            default:          dur = T_ALLRED;
        endcase
        return dur;
    endfunction

    phase_timer #(
        .RST_VAL (T_ALLRED)
    ) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .tick   (tick),
        .ld     (w_ld),
        .ld_val (w_ld_val),
        .count  (w_count),
        .expire (w_expire)
    );

    always_comb begin
        w_nxt_phase = r_phase;
        w_nxt_flash = r_flash;
        w_ld        = 1'b0;
        w_ld_val    = 8'd0;
        if (r_phase == PH_FLASH) begin
            // Flash has no timer; each tick either toggles or leaves via clearance.
            if (tick) begin
                if (night) begin
                    w_nxt_flash = ~r_flash;
                end else begin
                    w_nxt_phase = PH_AR_B;
                    w_nxt_flash = 1'b0;
                    w_ld        = 1'b1;
                    w_ld_val    = T_ALLRED;
                end
            end
        end else if (w_expire) begin
            case (r_phase)
                PH_NS_G: w_nxt_phase = PH_NS_Y;
                PH_NS_Y: w_nxt_phase = PH_AR_A;
                PH_AR_A: w_nxt_phase = night ? PH_FLASH : PH_EW_G;
                PH_EW_G: w_nxt_phase = PH_EW_Y;
                PH_EW_Y: w_nxt_phase = PH_AR_B;
                PH_AR_B: w_nxt_phase = night ? PH_FLASH :
                                       (r_ped_pending ? PH_WALK : PH_NS_G);
                default: w_nxt_phase = PH_NS_G;
            endcase
            w_ld        = 1'b1;
            w_ld_val    = phase_duration(w_nxt_phase);
            w_nxt_flash = (w_nxt_phase == PH_FLASH);
        end
    end

    assign w_enter_walk = (w_nxt_phase == PH_WALK) && (r_phase != PH_WALK);
    assign w_lamps      = lamp_decode(w_nxt_phase, w_nxt_flash);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_phase    <= PH_AR_B;
            r_flash    <= 1'b0;
            r_load     <= 1'b0;
            r_light_ns <= LAMP_R;
            r_light_ew <= LAMP_R;
        end else begin
            r_phase    <= w_nxt_phase;
            r_flash    <= w_nxt_flash;
            r_load     <= w_ld;
            r_light_ns <= w_lamps[5:3];
            r_light_ew <= w_lamps[2:0];
        end
    end

    // A request arriving in the same clk as WALK entry is absorbed by that WALK.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ped_pending <= 1'b0;
        end else if (w_enter_walk) begin
            r_ped_pending <= 1'b0;
        end else if (ped_req && (r_phase != PH_WALK) && (r_phase != PH_FLASH)) begin
            r_ped_pending <= 1'b1;
        end
    end

    assign light_ns = r_light_ns;
    assign light_ew = r_light_ew;
    assign count    = w_count;
    assign load     = r_load;
    assign ped_walk = (r_phase == PH_WALK);
    assign phase    = r_phase;

endmodule
`default_nettype wire
